// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its
// result FIFO.
//   XLEN / REG_AW        : data and register-address widths
//   grant_e              : winner of the write port in a given cycle
//   DEFAULT_DEPTH        : default MDU result FIFO depth
//   DEFAULT_STARVE_LIMIT : default number of consecutive losses a buffered
//                          MDU result tolerates before it is forced through
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam int unsigned DEFAULT_DEPTH        = 2;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO with no bypass. Written for the register results of
// multi-cycle units, where each entry is {rd, data}.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset (empties the FIFO)
//   push        : write push_data; ignored while full
//   push_data   : entry to store
//   pop         : drop the head entry; ignored while empty
//   pop_data    : head entry (only meaningful while !empty)
//   full, empty : occupancy flags
module wb_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Owner of the single register-file write port. Arbitrates between the
// in-order pipeline writeback and buffered results of the mul/div unit,
// and tracks outstanding MDU destinations for hazard detection in ID.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data      : pipeline register write request
//   wb_stall                    : pipeline WB must hold this cycle
//   mdu_issue/mdu_issue_rd      : ID dispatching an MDU op to rd
//   mdu_valid/mdu_rd/mdu_data   : MDU result offered
//   mdu_ready                   : result FIFO has room
//   rs1_addr/rs2_addr/rs_hazard : ID source lookup in the pending scoreboard
//   rf_we/rf_waddr/rf_wdata     : registered register-file write port
//
// Handshakes: an MDU result transfers on a cycle where mdu_valid && mdu_ready;
// while mdu_valid && !mdu_ready the MDU holds rd/data stable. A pipeline write
// retires on a cycle where wb_valid && !wb_stall; while stalled the pipeline
// holds wb_rd/wb_data stable.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              wb_stall,
    input  logic              mdu_issue,
    input  logic [REG_AW-1:0] mdu_issue_rd,
    input  logic              mdu_valid,
    input  logic [REG_AW-1:0] mdu_rd,
    input  logic [XLEN-1:0]   mdu_data,
    output logic              mdu_ready,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs_hazard,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_ne;
    logic [REG_AW+XLEN-1:0]   fifo_head;
    logic [REG_AW-1:0]        head_rd;
    logic [XLEN-1:0]          head_data;
    grant_e                   grant;
    logic [SW-1:0]            starve_cnt;
    logic [31:0]              pending;
    logic [31:0]              pending_next;

    assign mdu_ready = !fifo_full;
    assign fifo_ne   = !fifo_empty;
    assign head_rd   = fifo_head[REG_AW+XLEN-1:XLEN];
    assign head_data = fifo_head[XLEN-1:0];

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .W     (REG_AW + XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mdu_valid && mdu_ready),
        .push_data ({mdu_rd, mdu_data}),
        .pop       (grant == GNT_MDU),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The pipeline normally wins; a buffered MDU result takes the port when
    // the pipeline is idle or once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        grant = GNT_NONE;
        if (fifo_ne && (!wb_valid || starve_cnt == STARVE_MAX)) begin
            grant = GNT_MDU;
        end else if (wb_valid) begin
            grant = GNT_PIPE;
        end
    end

    assign wb_stall = wb_valid && (grant == GNT_MDU);

    // Set after clear so a re-issue of the retiring rd stays outstanding.
    always_comb begin
        pending_next = pending;
        if (grant == GNT_MDU) pending_next[head_rd] = 1'b0;
        if (mdu_issue && mdu_issue_rd != '0) pending_next[mdu_issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    assign rs_hazard = pending[rs1_addr] | pending[rs2_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pending    <= '0;
        end else begin
            pending <= pending_next;
            if (grant == GNT_MDU || !fifo_ne) begin
                starve_cnt <= '0;
            end else if (grant == GNT_PIPE && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // Writes to x0 still consume the grant but never assert the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (grant)
                GNT_MDU: begin
                    rf_we    <= (head_rd != '0);
                    rf_waddr <= head_rd;
                    rf_wdata <= head_data;
                end
                GNT_PIPE: begin
                    rf_we    <= (wb_rd != '0);
                    rf_waddr <= wb_rd;
                    rf_wdata <= wb_data;
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs_hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected register-file writes, {rd, data}, in retirement order.
    logic [36:0] exp_q[$];

    wb_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .mdu_issue    (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd),
        .mdu_valid    (mdu_valid),
        .mdu_rd       (mdu_rd),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs_hazard    (rs_hazard),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input string tag);
        logic [36:0] e;
        e = exp_q.pop_front();
        chk({tag, "_we"},   37'(rf_we), 37'(1));
        chk({tag, "_addr"}, 37'(rf_waddr), 37'(e[36:32]));
        chk({tag, "_data"}, 37'(rf_wdata), 37'(e[31:0]));
    endtask

    initial begin
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        mdu_issue = 1'b0; mdu_issue_rd = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        rs1_addr = '0; rs2_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",     37'(rf_we), 37'(0));
        chk("rst_waddr",  37'(rf_waddr), 37'(0));
        chk("rst_wdata",  37'(rf_wdata), 37'(0));
        chk("rst_stall",  37'(wb_stall), 37'(0));
        chk("rst_ready",  37'(mdu_ready), 37'(1));
        chk("rst_hazard", 37'(rs_hazard), 37'(0));
        rst_n = 1'b1;
        tick();

        // Pipe only
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
        #1 chk("pipe_stall", 37'(wb_stall), 37'(0));
        tick();
        chk("pipe_we",    37'(rf_we), 37'(1));
        chk("pipe_waddr", 37'(rf_waddr), 37'(3));
        chk("pipe_wdata", 37'(rf_wdata), 37'(32'h1234));
        wb_rd = 5'd0; wb_data = 32'h5555;
        tick();
        chk("pipe_rd0_we", 37'(rf_we), 37'(0));
        wb_rd = 5'd4; wb_data = 32'h00AA;
        tick();
        chk("pipe4_we",   37'(rf_we), 37'(1));
        chk("pipe4_addr", 37'(rf_waddr), 37'(4));
        wb_valid = 1'b0;
        tick();
        chk("idle_we",    37'(rf_we), 37'(0));
        chk("idle_waddr", 37'(rf_waddr), 37'(4));
        chk("idle_wdata", 37'(rf_wdata), 37'(32'h00AA));

        // MDU idle path with scoreboard
        mdu_issue = 1'b1; mdu_issue_rd = 5'd7; rs1_addr = 5'd7;
        #1 chk("mdu_haz_pre", 37'(rs_hazard), 37'(0));
        tick();
        mdu_issue = 1'b0;
        #1 chk("mdu_haz_set", 37'(rs_hazard), 37'(1));
        tick();
        tick();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hCAFE;
        #1 chk("mdu_ready", 37'(mdu_ready), 37'(1));
        tick();
        mdu_valid = 1'b0;
        chk("mdu_nobypass_we", 37'(rf_we), 37'(0));
        #1 chk("mdu_stall", 37'(wb_stall), 37'(0));
        chk("mdu_haz_held", 37'(rs_hazard), 37'(1));
        tick();
        chk("mdu_we",    37'(rf_we), 37'(1));
        chk("mdu_waddr", 37'(rf_waddr), 37'(7));
        chk("mdu_wdata", 37'(rf_wdata), 37'(32'hCAFE));
        chk("mdu_haz_clr", 37'(rs_hazard), 37'(0));
        rs1_addr = '0;

        // Starvation: pipe wins three times, then the MDU entry is forced
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hBEEF;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h101;
        tick();
        mdu_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            wb_rd = 5'(i); wb_data = 32'h100 + 32'(i);
            #1 chk("starve_stall0", 37'(wb_stall), 37'(0));
            tick();
            chk("starve_pipe_addr", 37'(rf_waddr), 37'(i));
        end
        wb_rd = 5'd5; wb_data = 32'h105;
        #1 chk("starve_stall1", 37'(wb_stall), 37'(1));
        tick();
        chk("starve_mdu_we",   37'(rf_we), 37'(1));
        chk("starve_mdu_addr", 37'(rf_waddr), 37'(10));
        chk("starve_mdu_data", 37'(rf_wdata), 37'(32'hBEEF));
        #1 chk("starve_release", 37'(wb_stall), 37'(0));
        tick();
        chk("starve_pipe5_addr", 37'(rf_waddr), 37'(5));
        chk("starve_pipe5_data", 37'(rf_wdata), 37'(32'h105));
        wb_valid = 1'b0;
        tick();

        // Backpressure: three MDU results into a two-entry FIFO
        wb_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wb_rd = 5'(11 + k); wb_data = 32'h200 + 32'(k);
            mdu_valid = 1'b1;
            mdu_rd   = (k < 2) ? 5'(20 + k) : 5'd22;
            mdu_data = (k < 2) ? 32'hD0 + 32'(k) : 32'hD2;
            #1 chk("bp_ready", 37'(mdu_ready), (k < 2) ? 37'(1) : 37'(0));
            exp_q.push_back({5'(11 + k), 32'h200 + 32'(k)});
            tick();
            expect_write("bp_pipe");
        end
        wb_rd = 5'd15; wb_data = 32'h204;
        #1 chk("bp_stall", 37'(wb_stall), 37'(1));
        chk("bp_full", 37'(mdu_ready), 37'(0));
        exp_q.push_back({5'd20, 32'hD0});
        tick();
        expect_write("bp_mdu20");
        #1 chk("bp_ready_after_pop", 37'(mdu_ready), 37'(1));
        chk("bp_stall_after_pop", 37'(wb_stall), 37'(0));
        exp_q.push_back({5'd15, 32'h204});
        tick();
        expect_write("bp_pipe15");
        mdu_valid = 1'b0; wb_valid = 1'b0;
        exp_q.push_back({5'd21, 32'hD1});
        tick();
        expect_write("bp_mdu21");
        exp_q.push_back({5'd22, 32'hD2});
        tick();
        expect_write("bp_mdu22");
        tick();
        chk("bp_drained_we", 37'(rf_we), 37'(0));

        // Same-cycle set and clear of rd=9
        mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
        tick();
        mdu_issue = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        tick();
        mdu_valid = 1'b0;
        mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
        rs1_addr = 5'd0; rs2_addr = 5'd9;
        tick();
        mdu_issue = 1'b0;
        chk("sc_we",    37'(rf_we), 37'(1));
        chk("sc_waddr", 37'(rf_waddr), 37'(9));
        chk("sc_wdata", 37'(rf_wdata), 37'(32'h99));
        chk("sc_haz_kept", 37'(rs_hazard), 37'(1));
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h9A;
        tick();
        mdu_valid = 1'b0;
        chk("sc_haz_wait", 37'(rs_hazard), 37'(1));
        tick();
        chk("sc2_waddr", 37'(rf_waddr), 37'(9));
        chk("sc2_wdata", 37'(rf_wdata), 37'(32'h9A));
        chk("sc_haz_clr", 37'(rs_hazard), 37'(0));
        rs2_addr = '0;

        // Reset mid-stream with two buffered results and pending[5]
        mdu_issue = 1'b1; mdu_issue_rd = 5'd5; rs1_addr = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h301;
        mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h55;
        tick();
        mdu_issue = 1'b0;
        mdu_rd = 5'd6; mdu_data = 32'h66;
        tick();
        mdu_valid = 1'b0;
        #1 chk("mr_full", 37'(mdu_ready), 37'(0));
        chk("mr_haz", 37'(rs_hazard), 37'(1));
        chk("mr_we_pre", 37'(rf_we), 37'(1));
        rst_n = 1'b0;
        #1 chk("mr_we",    37'(rf_we), 37'(0));
        chk("mr_waddr", 37'(rf_waddr), 37'(0));
        chk("mr_wdata", 37'(rf_wdata), 37'(0));
        chk("mr_ready", 37'(mdu_ready), 37'(1));
        chk("mr_hazard", 37'(rs_hazard), 37'(0));
        chk("mr_stall", 37'(wb_stall), 37'(0));
        #3 rst_n = 1'b1;
        wb_valid = 1'b0;
        tick();
        chk("mr_post_we0", 37'(rf_we), 37'(0));
        tick();
        chk("mr_post_we1", 37'(rf_we), 37'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port. Arbitrates between two requesters:
  - the in-order pipeline writeback, i.e. the final write-data select of the WB stage;
  - results returning from the multi-cycle mul/div unit (MDU).
- Buffers MDU results in a small FIFO and stalls the pipeline WB when the MDU must win.
- Keeps a pending-destination scoreboard so ID can detect RAW/WAW hazards on MDU destinations.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 3, maximum consecutive cycles a buffered MDU result may lose to the pipeline before it is forced through.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline WB has a register write this cycle (MemtoReg/jal/jalr/lui/U-type mux result already selected).
- wb_rd  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- wb_stall  out  1  pipeline WB must hold its instruction this cycle (combinational).
- mdu_issue  in  1  ID is dispatching an MDU op this cycle.
- mdu_issue_rd  in  5  destination of the dispatched MDU op.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU result destination.
- mdu_data  in  32  MDU result data.
- mdu_ready  out  1  FIFO can accept an MDU result (combinational).
- rs1_addr  in  5  ID source register 1.
- rs2_addr  in  5  ID source register 2.
- rs_hazard  out  1  a source register is pending in the scoreboard (combinational).
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, starve_cnt=0, pending=0.
  - Consequently wb_stall=0, mdu_ready=1, rs_hazard=0.
  - Reset mid-operation discards all buffered MDU results and pending bits.
- FIFO:
  - mdu_ready = !full.
  - Enqueue on mdu_valid && mdu_ready.
  - No bypass: an entry enqueued in cycle N is first eligible for grant in N+1.
  - Enqueue and dequeue may occur in the same cycle. Count stays the same and order is preserved.
- Grant, evaluated each cycle (fifo_ne = FIFO non-empty):
  - MDU granted if fifo_ne && (!wb_valid || starve_cnt==STARVE_LIMIT).
  - Else pipe granted if wb_valid.
  - Else idle.
- wb_stall = wb_valid && MDU granted.
- starve_cnt:
  - Cleared when the MDU is granted or the FIFO is empty.
  - Otherwise +1 when fifo_ne && pipe granted, saturating at STARVE_LIMIT.
- Write port, latency 1:
  - On the edge after a grant: rf_we=1, rf_waddr/rf_wdata = the winner's rd/data.
  - If rd==0: rf_we=0, but the grant still consumes the request (FIFO pops, pipe advances).
  - Idle cycle: rf_we=0; rf_waddr/rf_wdata hold their last value.
- Scoreboard (32-bit pending):
  - Set pending[mdu_issue_rd] on mdu_issue with rd!=0.
  - Clear pending[rd] when that FIFO entry is granted.
  - Set and clear of the same rd in the same cycle: set wins (the newer op is outstanding).
  - Bit 0 is never set.
  - rs_hazard = pending[rs1_addr] | pending[rs2_addr].
- Pipe writes to a pending rd are prevented upstream by rs_hazard/WAW checking in ID. This block does not check them.
- mdu_valid while full: the MDU holds the result; no loss.

Decomposition:
- Shared package:
  - XLEN=32, REG_AW=5.
  - grant enum {GNT_NONE, GNT_PIPE, GNT_MDU}.
  - Default DEPTH/STARVE_LIMIT constants.
- Sub-module: wb_result_fifo — a parameterised synchronous FIFO of {rd, data} with full/empty and async active-low reset. It is reusable by other multi-cycle units.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with 2 FIFO entries and pending[5]=1 -> all registered outputs 0 immediately, mdu_ready=1, rs_hazard=0 for rs1=5.
2. Pipe only: wb_valid=1, rd=3, data=0x1234 for 1 cycle -> next cycle rf_we=1, waddr=3, wdata=0x1234, wb_stall=0; rd=0 -> rf_we=0.
3. MDU idle path: mdu_issue rd=7 at N -> rs_hazard=1 for rs1=7. mdu_valid rd=7, data=0xCAFE at N+4 -> grant at N+5, rf_we/waddr=7 at N+6, rs_hazard=0 from N+6.
4. Starvation: 1 FIFO entry with wb_valid held high -> pipe wins 3 cycles, then cycle 4 wb_stall=1 and the MDU entry is written; starve_cnt returns to 0.
5. Backpressure: DEPTH=2, wb_valid held high with limit not reached, push 3 MDU results -> mdu_ready=0 after 2; the third is accepted on the cycle after the first pop; write order matches arrival.
6. Same-cycle set/clear: FIFO head rd=9 granted while mdu_issue rd=9 -> pending[9] stays 1; the next rd=9 retire clears it.
